rx_frame_manager: RTL and testbench

- Sits between rx_receiver and the consumer logic (display/host) on the Rx node.
- Classifies each decoded frame by CRC status and destination ID against the node's own ID.
- Buffers accepted frames in a small first-word-fall-through FIFO.
- Schedules ACK/NAK requests toward the Tx side over a request/grant handshake, and keeps saturating statistics counters.

---
 rtl/rx_frame_manager.sv | 183 ++++++++++++++++++
 tb/tb_rx_frame_manager.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_manager.sv
// Receive-side frame manager: classifies decoded frames, buffers accepted ones in a
// first-word-fall-through FIFO, schedules ACK/NAK requests and keeps saturating statistics.
module rx_frame_manager #(
   parameter int PAYLOAD_W = 128,
   parameter int ID_W      = 2,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 8,
   parameter bit BCAST_EN  = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ID_W-1:0]          my_id,
   input  logic                     frame_valid,
   input  logic                     crc_error,
   input  logic [ID_W-1:0]          dest_id,
   input  logic [ID_W-1:0]          src_id,
   input  logic [PAYLOAD_W-1:0]     payload,
   input  logic                     rd_en,
   output logic                     out_valid,
   output logic [ID_W-1:0]          out_src,
   output logic                     out_bcast,
   output logic [PAYLOAD_W-1:0]     out_payload,
   output logic [$clog2(DEPTH):0]   buf_count,
   output logic                     ack_req,
   output logic                     ack_nak,
   output logic [ID_W-1:0]          ack_dest,
   input  logic                     ack_gnt,
   output logic                     ack_lost,
   input  logic                     clr_stats,
   output logic [CNT_W-1:0]         cnt_ok,
   output logic [CNT_W-1:0]         cnt_crc,
   output logic [CNT_W-1:0]         cnt_addr,
   output logic [CNT_W-1:0]         cnt_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, REQ} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic                 fv_q;
   logic                 evt, addr_me, bcast, match, pop, full, push;
   logic                 inc_ok, inc_crc, inc_addr, inc_ovf;
   logic                 ack_ev, ack_ev_nak;
   logic [AW-1:0]        rd_ptr, wr_ptr;
   logic [CW-1:0]        count;
   logic [PAYLOAD_W-1:0] mem_payload [DEPTH];
   logic [ID_W-1:0]      mem_src     [DEPTH];
   logic                 mem_bcast   [DEPTH];
   state_t               state;

   // Event detection and classification
   always_comb begin
      evt        = frame_valid & ~fv_q;
      addr_me    = (dest_id == my_id);
      // A frame addressed to this node by its own ID is unicast even if that ID is all-ones.
      bcast      = BCAST_EN && (&dest_id) && !addr_me;
      match      = addr_me || bcast;
      pop        = rd_en && (count != '0);
      full       = (count == CW'(DEPTH)) && !pop;
      push       = 1'b0;
      inc_ok     = 1'b0;
      inc_crc    = 1'b0;
      inc_addr   = 1'b0;
      inc_ovf    = 1'b0;
      ack_ev     = 1'b0;
      ack_ev_nak = 1'b0;
      if (evt) begin
         if (crc_error) begin
            inc_crc    = 1'b1;
            ack_ev     = addr_me;
            ack_ev_nak = 1'b1;
         end else if (!match) begin
            inc_addr   = 1'b1;
         end else if (!full) begin
            push       = 1'b1;
            inc_ok     = 1'b1;
            ack_ev     = !bcast;
         end else begin
            inc_ovf    = 1'b1;
            ack_ev     = !bcast;
            ack_ev_nak = 1'b1;
         end
      end
   end

   // Frame buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         fv_q   <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_payload[i] <= '0;
            mem_src[i]     <= '0;
            mem_bcast[i]   <= 1'b0;
         end
      end else begin
         fv_q <= frame_valid;
         if (push) begin
            mem_payload[wr_ptr] <= payload;
            mem_src[wr_ptr]     <= src_id;
            mem_bcast[wr_ptr]   <= bcast;
            wr_ptr              <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign out_valid   = (count != '0);
   assign out_payload = mem_payload[rd_ptr];
   assign out_src     = mem_src[rd_ptr];
   assign out_bcast   = mem_bcast[rd_ptr];
   assign buf_count   = count;

   // Statistics counters: clear beats a coincident increment
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         cnt_ok   <= '0;
         cnt_crc  <= '0;
         cnt_addr <= '0;
         cnt_ovf  <= '0;
      end else begin
         if (inc_ok)   cnt_ok   <= sat_inc(cnt_ok);
         if (inc_crc)  cnt_crc  <= sat_inc(cnt_crc);
         if (inc_addr) cnt_addr <= sat_inc(cnt_addr);
         if (inc_ovf)  cnt_ovf  <= sat_inc(cnt_ovf);
      end
   end

   // Ack request FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ack_req  <= 1'b0;
         ack_nak  <= 1'b0;
         ack_dest <= '0;
         ack_lost <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ack_ev) begin
                  state    <= REQ;
                  ack_req  <= 1'b1;
                  ack_nak  <= ack_ev_nak;
                  ack_dest <= src_id;
               end
            end
            REQ: begin
               if (ack_gnt) begin
                  if (ack_ev) begin
                     ack_nak  <= ack_ev_nak;
                     ack_dest <= src_id;
                  end else begin
                     state   <= IDLE;
                     ack_req <= 1'b0;
                  end
               end else if (ack_ev) begin
                  ack_lost <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               ack_req <= 1'b0;
            end
         endcase
         if (clr_stats)
            ack_lost <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_frame_manager.sv
// Directed bench for rx_frame_manager: classification, FIFO ordering, ack handshake,
// counter saturation/clear and mid-stream reset.
module tb_rx_frame_manager;

   localparam int PW = 128;
   localparam int IW = 2;
   localparam int DEPTH = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst, frame_valid, crc_error, rd_en, ack_gnt, clr_stats;
   logic [IW-1:0] my_id, dest_id, src_id;
   logic [PW-1:0] payload;
   logic          out_valid, out_bcast, ack_req, ack_nak, ack_lost;
   logic [IW-1:0] out_src, ack_dest;
   logic [PW-1:0] out_payload;
   logic [$clog2(DEPTH):0] buf_count;
   logic [CW-1:0] cnt_ok, cnt_crc, cnt_addr, cnt_ovf;

   int n_checks = 0;
   int n_fail = 0;

   logic [PW-1:0] p0, q [5];
   logic [IW-1:0] qs [5];

   always #5 clk = ~clk;

   rx_frame_manager #(.PAYLOAD_W(PW), .ID_W(IW), .DEPTH(DEPTH), .CNT_W(CW), .BCAST_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .my_id(my_id), .frame_valid(frame_valid), .crc_error(crc_error),
      .dest_id(dest_id), .src_id(src_id), .payload(payload), .rd_en(rd_en),
      .out_valid(out_valid), .out_src(out_src), .out_bcast(out_bcast), .out_payload(out_payload),
      .buf_count(buf_count), .ack_req(ack_req), .ack_nak(ack_nak), .ack_dest(ack_dest),
      .ack_gnt(ack_gnt), .ack_lost(ack_lost), .clr_stats(clr_stats),
      .cnt_ok(cnt_ok), .cnt_crc(cnt_crc), .cnt_addr(cnt_addr), .cnt_ovf(cnt_ovf)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [IW-1:0] d, input logic [IW-1:0] s, input logic crc,
                        input logic [PW-1:0] p, input int hold);
      dest_id = d; src_id = s; crc_error = crc; payload = p; frame_valid = 1'b1;
      repeat (hold) tick;
      frame_valid = 1'b0;
      tick;
   endtask

   initial begin
      rst = 1'b1; frame_valid = 1'b0; crc_error = 1'b0; rd_en = 1'b0; ack_gnt = 1'b0;
      clr_stats = 1'b0; my_id = 2'd1; dest_id = '0; src_id = '0; payload = '0;
      p0 = 128'h00112233445566778899AABBCCDDEEFF;
      q[0] = 128'hA0; q[1] = 128'hA1; q[2] = 128'hA2; q[3] = 128'hA3; q[4] = 128'hA4;
      qs[0] = 2'd0; qs[1] = 2'd2; qs[2] = 2'd3; qs[3] = 2'd0; qs[4] = 2'd3;
      tick; tick;
      rst = 1'b0;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_buf_count", 128'(buf_count), 128'(0));
      check("rst_ack_req", 128'(ack_req), 128'(0));
      check("rst_cnt_ok", 128'(cnt_ok), 128'(0));
      check("rst_out_payload", out_payload, 128'(0));

      // held level gives one event
      frame(2'd1, 2'd2, 1'b0, p0, 5);
      check("t1_buf_count", 128'(buf_count), 128'(1));
      check("t1_out_payload", out_payload, p0);
      check("t1_out_src", 128'(out_src), 128'(2));
      check("t1_cnt_ok", 128'(cnt_ok), 128'(1));
      check("t1_ack_req", 128'(ack_req), 128'(1));
      check("t1_ack_nak", 128'(ack_nak), 128'(0));
      check("t1_ack_dest", 128'(ack_dest), 128'(2));
      check("t1_ack_lost", 128'(ack_lost), 128'(0));
      ack_gnt = 1'b1; tick; ack_gnt = 1'b0;
      check("t1_ack_dropped", 128'(ack_req), 128'(0));
      rd_en = 1'b1; tick; rd_en = 1'b0;
      check("t1_popped", 128'(buf_count), 128'(0));

      // CRC errors
      frame(2'd1, 2'd2, 1'b1, 128'h55, 1);
      check("t2_cnt_crc", 128'(cnt_crc), 128'(1));
      check("t2_no_push", 128'(buf_count), 128'(0));
      check("t2_nak_req", 128'(ack_req), 128'(1));
      check("t2_nak", 128'(ack_nak), 128'(1));
      check("t2_nak_dest", 128'(ack_dest), 128'(2));
      ack_gnt = 1'b1; tick; ack_gnt = 1'b0;
      frame(2'd0, 2'd3, 1'b1, 128'h66, 1);
      check("t2_cnt_crc2", 128'(cnt_crc), 128'(2));
      check("t2_no_req", 128'(ack_req), 128'(0));

      // address mismatch and broadcast
      frame(2'd0, 2'd2, 1'b0, 128'h77, 1);
      check("t3_cnt_addr", 128'(cnt_addr), 128'(1));
      check("t3_no_ack", 128'(ack_req), 128'(0));
      check("t3_no_push", 128'(buf_count), 128'(0));
      frame(2'd3, 2'd0, 1'b0, 128'h88, 1);
      check("t3_bc_count", 128'(buf_count), 128'(1));
      check("t3_bc_flag", 128'(out_bcast), 128'(1));
      check("t3_bc_payload", out_payload, 128'h88);
      check("t3_bc_no_ack", 128'(ack_req), 128'(0));
      check("t3_cnt_ok", 128'(cnt_ok), 128'(2));
      rd_en = 1'b1; tick; rd_en = 1'b0;

      // fill, overflow, push with simultaneous pop
      ack_gnt = 1'b1;
      for (int i = 0; i < 4; i++) frame(2'd1, qs[i], 1'b0, q[i], 1);
      check("t4_full", 128'(buf_count), 128'(4));
      check("t4_cnt_ok", 128'(cnt_ok), 128'(6));
      dest_id = 2'd1; src_id = 2'd2; crc_error = 1'b0; payload = 128'hBAD; frame_valid = 1'b1;
      tick;
      check("t4_cnt_ovf", 128'(cnt_ovf), 128'(1));
      check("t4_ovf_count", 128'(buf_count), 128'(4));
      check("t4_ovf_req", 128'(ack_req), 128'(1));
      check("t4_ovf_nak", 128'(ack_nak), 128'(1));
      check("t4_ovf_dest", 128'(ack_dest), 128'(2));
      frame_valid = 1'b0; tick;
      src_id = qs[4]; payload = q[4]; frame_valid = 1'b1; rd_en = 1'b1;
      tick;
      frame_valid = 1'b0; rd_en = 1'b0;
      check("t4_pp_count", 128'(buf_count), 128'(4));
      check("t4_pp_cnt_ok", 128'(cnt_ok), 128'(7));
      check("t4_pp_cnt_ovf", 128'(cnt_ovf), 128'(1));
      tick;
      for (int i = 1; i < 5; i++) begin
         check($sformatf("t4_drain_payload%0d", i), out_payload, q[i]);
         check($sformatf("t4_drain_src%0d", i), 128'(out_src), 128'(qs[i]));
         rd_en = 1'b1; tick; rd_en = 1'b0;
      end
      check("t4_empty", 128'(out_valid), 128'(0));
      check("t4_no_lost", 128'(ack_lost), 128'(0));
      ack_gnt = 1'b0;

      // lost ack while request pending
      frame(2'd1, 2'd2, 1'b0, 128'hC0, 1);
      frame(2'd1, 2'd0, 1'b0, 128'hC1, 1);
      check("t5_ack_dest", 128'(ack_dest), 128'(2));
      check("t5_ack_nak", 128'(ack_nak), 128'(0));
      check("t5_ack_lost", 128'(ack_lost), 128'(1));
      check("t5_ack_req", 128'(ack_req), 128'(1));
      check("t5_count", 128'(buf_count), 128'(2));
      ack_gnt = 1'b1; tick; ack_gnt = 1'b0;
      check("t5_req_drop", 128'(ack_req), 128'(0));
      rd_en = 1'b1; tick; tick; rd_en = 1'b0;
      check("t5_drained", 128'(buf_count), 128'(0));

      // saturation
      ack_gnt = 1'b1; rd_en = 1'b1;
      for (int i = 0; i < 300; i++) frame(2'd1, 2'd2, 1'b0, 128'(i), 1);
      ack_gnt = 1'b0; rd_en = 1'b0;
      check("t6_cnt_ok_sat", 128'(cnt_ok), 128'(255));
      check("t6_cnt_crc", 128'(cnt_crc), 128'(2));
      check("t6_cnt_addr", 128'(cnt_addr), 128'(1));
      check("t6_cnt_ovf", 128'(cnt_ovf), 128'(1));
      check("t6_lost_sticky", 128'(ack_lost), 128'(1));
      check("t6_empty", 128'(buf_count), 128'(0));
      clr_stats = 1'b1; tick; clr_stats = 1'b0;
      check("t6_clr_ok", 128'(cnt_ok), 128'(0));
      check("t6_clr_crc", 128'(cnt_crc), 128'(0));
      check("t6_clr_addr", 128'(cnt_addr), 128'(0));
      check("t6_clr_ovf", 128'(cnt_ovf), 128'(0));
      check("t6_clr_lost", 128'(ack_lost), 128'(0));

      // clear coincident with increment, then mid-stream reset
      dest_id = 2'd1; src_id = 2'd2; crc_error = 1'b0; payload = 128'hD0;
      frame_valid = 1'b1; clr_stats = 1'b1;
      tick;
      clr_stats = 1'b0; frame_valid = 1'b0;
      check("t7_clr_wins", 128'(cnt_ok), 128'(0));
      check("t7_clr_push", 128'(buf_count), 128'(1));
      tick;
      frame(2'd1, 2'd3, 1'b0, 128'hD1, 1);
      check("t7_count2", 128'(buf_count), 128'(2));
      check("t7_cnt_ok", 128'(cnt_ok), 128'(1));
      check("t7_req", 128'(ack_req), 128'(1));
      src_id = 2'd0; payload = 128'hD2; frame_valid = 1'b1; rst = 1'b1;
      tick;
      rst = 1'b0;
      check("t7_rst_count", 128'(buf_count), 128'(0));
      check("t7_rst_valid", 128'(out_valid), 128'(0));
      check("t7_rst_req", 128'(ack_req), 128'(0));
      check("t7_rst_cnt_ok", 128'(cnt_ok), 128'(0));
      check("t7_rst_lost", 128'(ack_lost), 128'(0));
      tick;
      check("t7_post_rst_push", 128'(buf_count), 128'(1));
      check("t7_post_rst_payload", out_payload, 128'hD2);
      check("t7_post_rst_req", 128'(ack_req), 128'(1));
      check("t7_post_rst_dest", 128'(ack_dest), 128'(0));
      frame_valid = 1'b0;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
